// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkg
//  Description : Definitions shared by the stream blocks (mux, FIFO and the
//                stages that follow them): default data width and depth,
//                and a pointer-width helper built on $clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

  localparam int AXIS_WIDTH_DEFAULT = 4;
  localparam int AXIS_DEPTH_DEFAULT = 8;

  // Index width for a DEPTH-entry array. Floors at 1 so that the declared
  // range [w-1:0] stays legal even if a caller passes depth 1.
  function automatic int axis_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : axis_pkg
`default_nettype wire

// File: rtl/axis_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_fifo_if
//  Description : Single valid/ready stream bundle.
//                Signals: data [WIDTH-1:0], valid, ready.
//                master drives data/valid and samples ready;
//                slave samples data/valid and drives ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_fifo_if #(
  parameter int WIDTH = axis_pkg::AXIS_WIDTH_DEFAULT
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface : axis_fifo_if
`default_nettype wire

// File: rtl/axis_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axis_fifo_mem
//  Description : DEPTH x WIDTH register array for the FIFO. It writes on the
//                clock edge, reads asynchronously, and its synchronous reset
//                clears every entry to zero.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                we, waddr, wdata - write enable / address / data
//                raddr, rdata     - asynchronous read address / data
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_mem
  import axis_pkg::*;
#(
  parameter int WIDTH = AXIS_WIDTH_DEFAULT,
  parameter int DEPTH = AXIS_DEPTH_DEFAULT,
  localparam int AW   = axis_ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : axis_fifo_mem
`default_nettype wire

// File: rtl/axis_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_fifo
//  Description : Synchronous first-word-fall-through stream FIFO. It absorbs
//                up to DEPTH words of consumer backpressure before it drops
//                ready toward the upstream mux.
//  Ports       : clk    - single clock, rising edge
//                rst    - synchronous active-high reset
//                in_if  - write side (slave): data/valid in, ready out
//                out_if - read side (master): data/valid out, ready in
//                count  - occupancy 0..DEPTH; this port exists only when
//                         AXIS_FIFO_COUNT_EN is defined
//  Config      : `define AXIS_FIFO_COUNT_EN adds the count port
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo
  import axis_pkg::*;
#(
  parameter int WIDTH = AXIS_WIDTH_DEFAULT,
  parameter int DEPTH = AXIS_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  axis_fifo_if.slave  in_if,
  axis_fifo_if.master out_if
`ifdef AXIS_FIFO_COUNT_EN
  ,
  output logic [axis_ptr_width(DEPTH):0] count
`endif
);

  localparam int               PTR_W    = axis_ptr_width(DEPTH);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q,    occ_d;

  logic push;
  logic pop;

  // Ready is forced low while rst is high so that nothing is accepted in a
  // reset cycle. Full blocks pushes even when a pop occurs in the same cycle.
  assign in_if.ready  = ~rst & (occ_q != OCC_FULL);
  assign out_if.valid = (occ_q != '0);

  assign push = in_if.valid & in_if.ready;
  assign pop  = out_if.valid & out_if.ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  axis_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_if.data),
    .raddr (rd_ptr_q),
    .rdata (out_if.data)
  );

`ifdef AXIS_FIFO_COUNT_EN
  assign count = occ_q;
`endif

endmodule : axis_fifo
`default_nettype wire

// File: tb/tb_axis_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_fifo
//  Description : Self-checking bench for axis_fifo (WIDTH=4, DEPTH=8).
//                A negedge monitor records every accepted input word in a
//                queue and compares each popped output word against the
//                queue head. The scenario tasks add their own inline checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  axis_fifo_if #(.WIDTH(WIDTH)) in_if ();
  axis_fifo_if #(.WIDTH(WIDTH)) out_if ();

`ifdef AXIS_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  axis_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in_if  (in_if),
    .out_if (out_if)
`ifdef AXIS_FIFO_COUNT_EN
    ,
    .count  (count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] sb [$];

  // Scoreboard. At negedge the inputs for the next rising edge are already
  // settled, so any handshake seen here is the one that edge commits.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_if.valid && out_if.ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_pop: got %h, expected no output (queue empty)", out_if.data);
        end else begin
          logic [WIDTH-1:0] exp_w;
          exp_w = sb.pop_front();
          if (out_if.data !== exp_w) begin
            n_err++;
            $display("FAIL sb_data: got %h, expected %h", out_if.data, exp_w);
          end
        end
      end
      if (in_if.valid && in_if.ready) begin
        sb.push_back(in_if.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if (in_if.ready !== 1'b0) begin
        n_err++;
        $display("FAIL reset_in_ready: got %b, expected 0", in_if.ready);
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_if.ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_in_ready: got %b, expected 1", in_if.ready);
    end
    n_vec++;
    if (out_if.valid !== 1'b0 || out_if.data !== '0) begin
      n_err++;
      $display("FAIL reset_out: got valid=%b data=%h, expected 0/0", out_if.valid, out_if.data);
    end
`ifdef AXIS_FIFO_COUNT_EN
    n_vec++;
    if (count !== '0) begin
      n_err++;
      $display("FAIL reset_count: got %0d, expected 0", count);
    end
`endif
    tick();
  endtask

  task automatic test_fill();
    out_if.ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = WIDTH'(i);
      @(negedge clk);
      n_vec++;
      if (in_if.ready !== 1'b1) begin
        n_err++;
        $display("FAIL fill_ready[%0d]: got %b, expected 1", i, in_if.ready);
      end
      tick();
    end
    in_if.data = 4'h9;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++;
      if (in_if.ready !== 1'b0) begin
        n_err++;
        $display("FAIL full_ready: got %b, expected 0", in_if.ready);
      end
      n_vec++;
      if (out_if.valid !== 1'b1 || out_if.data !== 4'h1) begin
        n_err++;
        $display("FAIL full_head: got valid=%b data=%h, expected 1/1", out_if.valid, out_if.data);
      end
`ifdef AXIS_FIFO_COUNT_EN
      n_vec++;
      if (count !== 4'd8) begin
        n_err++;
        $display("FAIL full_count: got %0d, expected 8", count);
      end
`endif
      tick();
    end
    in_if.valid = 1'b0;
  endtask

  task automatic test_drain();
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_if.valid !== 1'b1 || out_if.data !== WIDTH'(i + 1)) begin
        n_err++;
        $display("FAIL drain[%0d]: got valid=%b data=%h, expected 1/%h",
                 i, out_if.valid, out_if.data, WIDTH'(i + 1));
      end
      if (i == 1) begin
        n_vec++;
        if (in_if.ready !== 1'b1) begin
          n_err++;
          $display("FAIL drain_ready: got %b, expected 1", in_if.ready);
        end
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: got valid=%b, expected 0", out_if.valid);
    end
    tick();
  endtask

  task automatic test_stream();
    in_if.valid = 1'b1;
    out_if.ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_if.data = WIDTH'(i + 3);
      @(negedge clk);
      if (i == 0) begin
        n_vec++;
        if (out_if.valid !== 1'b0) begin
          n_err++;
          $display("FAIL stream_first: got valid=%b, expected 0", out_if.valid);
        end
      end else begin
        n_vec++;
        if (out_if.valid !== 1'b1 || out_if.data !== WIDTH'(i + 2)) begin
          n_err++;
          $display("FAIL stream[%0d]: got valid=%b data=%h, expected 1/%h",
                   i, out_if.valid, out_if.data, WIDTH'(i + 2));
        end
`ifdef AXIS_FIFO_COUNT_EN
        n_vec++;
        if (count !== 4'd1) begin
          n_err++;
          $display("FAIL stream_count[%0d]: got %0d, expected 1", i, count);
        end
`endif
      end
      tick();
    end
    in_if.valid = 1'b0;
    tick();
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL stream_end: got valid=%b pending=%0d, expected 0/0", out_if.valid, sb.size());
    end
    tick();
  endtask

  task automatic test_wrap();
    int sent;
    int cyc;
    out_if.ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = WIDTH'($urandom);
      tick();
    end
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    sent = 0;
    cyc  = 0;
    in_if.data = WIDTH'($urandom);
    while (sent < 8 && cyc < 200) begin
      logic acc;
      in_if.valid  = 1'b1;
      out_if.ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_if.ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        in_if.data = WIDTH'($urandom);
      end
    end
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    cyc = 0;
    while (out_if.valid && cyc < 50) begin
      tick();
      cyc++;
    end
    @(negedge clk);
    n_vec++;
    if (sent != 8 || out_if.valid !== 1'b0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL wrap_done: got sent=%0d valid=%b pending=%0d, expected 8/0/0",
               sent, out_if.valid, sb.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = WIDTH'(i + 1);
      tick();
    end
    in_if.valid = 1'b0;
`ifdef AXIS_FIFO_COUNT_EN
    @(negedge clk);
    n_vec++;
    if (count !== 4'd5) begin
      n_err++;
      $display("FAIL mid_count_pre: got %0d, expected 5", count);
    end
`endif
    rst = 1'b1;
    out_if.ready = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_valid: got %b, expected 0", out_if.valid);
    end
`ifdef AXIS_FIFO_COUNT_EN
    n_vec++;
    if (count !== '0) begin
      n_err++;
      $display("FAIL mid_count: got %0d, expected 0", count);
    end
`endif
    in_if.valid = 1'b1;
    in_if.data  = 4'hA;
    tick();
    in_if.valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b1 || out_if.data !== 4'hA) begin
      n_err++;
      $display("FAIL mid_first: got valid=%b data=%h, expected 1/a", out_if.valid, out_if.data);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (out_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_after: got valid=%b, expected 0", out_if.valid);
    end
  endtask

  initial begin
    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_axis_fifo
`default_nettype wire
